aes_round_ctrl: RTL
===================

# aes_round_ctrl

Iterative AES-128 encryption sequencer. It owns the 128-bit state register and steps one external round datapath through the initial AddRoundKey and rounds 1–10. That datapath is SubBytes → shift_rows → MixColumns → AddRoundKey, with MixColumns bypassed in round 10. Round keys are fetched one at a time from the key-expansion block over a req/valid handshake. It sits between the top-level I/O wrapper (plaintext/start in, ciphertext/done out) and the shared round datapath.

## Interface
Parameters:
- NR, 10, number of full rounds after the initial AddRoundKey (fixed 10 for AES-128; 4-bit counter).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin encryption; sampled only in IDLE.
- plaintext  input  128  latched on accepted start.
- busy  output  1  high in INIT and ROUND.
- done  output  1  one-cycle pulse, ciphertext valid.
- ciphertext  output  128  equals state_q; holds after done until the next accepted start.
- state_q  output  128  state register, fed to the round datapath.
- round_out  input  128  combinational datapath result for state_q, rk and skip_mix.
- round_idx  output  4  current round, 0..10.
- skip_mix  output  1  high when round_idx == NR (final round, no MixColumns).
- rk_req  output  1  round-key request for round rk_idx.
- rk_idx  output  4  requested key index, always equal to round_idx.
- rk_valid  input  1  key handshake; rk is valid when rk_valid && rk_req.
- rk  input  128  round key.

## Operation
- FSM states: IDLE, INIT, ROUND, DONE.
- IDLE:
  - busy=0, rk_req=0.
  - On start: pt_q<=plaintext, round_idx<=0, go to INIT.
- INIT:
  - rk_req=1, rk_idx=0.
  - On rk_valid: state_q<=pt_q^rk, round_idx<=1, go to ROUND.
  - Otherwise hold all registers.
- ROUND:
  - rk_req=1, rk_idx=round_idx.
  - On rk_valid: state_q<=round_out.
  - If round_idx==NR, go to DONE; otherwise round_idx<=round_idx+1.
  - Without rk_valid, hold (wait states allowed indefinitely).
- DONE:
  - done=1, busy=0, rk_req=0.
  - Unconditionally go to IDLE next cycle.
- skip_mix is combinational: (state==ROUND && round_idx==NR).
- round_idx never exceeds NR and never wraps.
- Boundary conditions:
  - start while busy or in DONE: ignored, no effect on pt_q.
  - rk_valid while rk_req=0: ignored.
  - start held high continuously: a new encryption begins on the IDLE cycle after each DONE.
  - rst mid-operation: immediate return to IDLE. No done pulse, no rk_req. The datapath result for the aborted block is discarded.
- Reset values: state=IDLE, state_q=0, pt_q=0, round_idx=0; busy=0, done=0, rk_req=0, skip_mix=0; ciphertext=0.

## Timing
- Start accepted at edge E0 → INIT during the E0–E1 cycle.
- With zero-wait keys (rk_valid tied high):
  - E1 loads round 0.
  - E2..E11 load rounds 1..10.
  - done is high during the E11–E12 cycle.
  - Latency is 11 cycles from start edge to done, or 12 clocks from start to the next IDLE.
- Each cycle rk_valid is low during rk_req adds exactly one cycle.
- rk_req/rk_idx are Moore outputs (state-decoded); rk and rk_valid are consumed on the same edge.
- Throughput: one block per 12 cycles minimum.

## Test plan
- Reset and idle:
  - Apply rst mid-sim.
  - Required: all outputs 0 immediately (async).
  - Required: after release with start=0, rk_req stays 0 and busy stays 0 for 20 cycles.
- Identity datapath, zero wait:
  - Bench model: round_out=state_q^rk, rk_i={16{8'(i)}}, rk_valid=1, plaintext=0.
  - Required: ciphertext={16{8'h0b}}, done exactly 11 cycles after start, rk_idx sequence 0..10.
  - Required: skip_mix high only during round 10.
- Key wait states: as above, but rk_valid low for 3 cycles before every key. Required: same ciphertext, done at 11+33=44 cycles, state_q unchanged during waits.
- FIPS-197 C.1 with the real round datapath and key expander:
  - plaintext=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f.
  - Required: ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
- Start during busy and back-to-back:
  - Pulse start in round 5 with different plaintext. Required: ignored, original result unchanged.
  - Hold start high. Required: second encryption begins the cycle after DONE with a fresh pt_q.
- Reset mid-round: assert rst during round 6. Required: IDLE, no done. A subsequent start yields the correct FIPS-197 ciphertext.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 round sequencer with round-key fetch handshake
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext,
    output logic [127:0] state_q,
    input  logic [127:0] round_out,
    output logic [3:0]   round_idx,
    output logic         skip_mix,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic         rk_valid,
    input  logic [127:0] rk
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic [1:0]   state;
    logic [127:0] pt_q;
    logic [3:0]   round_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pt_q    <= '0;
            state_q <= '0;
            round_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pt_q    <= plaintext;
                        round_q <= 4'd0;
                        state   <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (rk_valid) begin
                        state_q <= pt_q ^ rk;
                        round_q <= 4'd1;
                        state   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    // The final round leaves round_q at NR so the index never wraps.
                    if (rk_valid) begin
                        state_q <= round_out;
                        if (round_q == LAST_ROUND) begin
                            state <= S_DONE;
                        end else begin
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state == S_INIT) || (state == S_ROUND);
    assign done       = (state == S_DONE);
    assign rk_req     = busy;
    assign rk_idx     = round_q;
    assign round_idx  = round_q;
    assign skip_mix   = (state == S_ROUND) && (round_q == LAST_ROUND);
    assign ciphertext = state_q;

endmodule
